press_sprite_draw: RTL and testbench

- Renderer stage directly upstream and downstream of the 168x12 "press" prompt ROM.
- Takes VGA pixel coordinates and converts them to the ROM's 11-bit address.
- Consumes the ROM's 1-cycle-registered 8-bit pixel and emits a delay-aligned pixel with transparency keying.
- A frame-counted blink FSM gates visibility of the prompt on the title screen; the downstream colour mux merges the output.

---
 rtl/press_sprite_draw.sv | 137 +++++++++++++
 tb/tb_press_sprite_draw.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/press_sprite_draw.sv
// press_sprite_draw: address generation, blink gating and transparency keying
// for the 168x12 "press" prompt ROM. The ROM sits between stage 1 and stage 3
// of this block and adds one registered cycle, giving a 3-cycle total latency.
//
// Pipeline handshake: there is no valid/ready flow control. Every cycle carries
// exactly one pixel slot: inputs in, result out three edges later, no stalls.
module press_sprite_draw #(
  parameter int          X0           = 236,
  parameter int          Y0           = 400,
  parameter int          SPR_W        = 168,
  parameter int          SPR_H        = 12,
  parameter logic [7:0]  KEY_COLOR    = 8'h00,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        i_clk2,
  input  logic        i_rst,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  input  logic        i_active,
  input  logic        i_frame_tick,
  input  logic        i_enable,
  output logic [10:0] o_rom_addr,
  input  logic [7:0]  i_rom_data,
  output logic [7:0]  o_pixel,
  output logic        o_draw
);

  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + SPR_W);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + SPR_H);
  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HIDE = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_frame_cnt;

  logic       r_hit1;
  logic       r_vis1;
  logic       r_hit2;
  logic       r_vis2;

  logic       w_hit;
  logic [3:0] w_dy;
  logic [7:0] w_dx;
  logic [10:0] w_addr;
  logic       w_draw_next;

  // Box test and row/column offsets; offsets are only meaningful when w_hit
  assign w_hit = i_active &&
                 (i_x >= X_LO) && (i_x < X_HI) &&
                 (i_y >= Y_LO) && (i_y < Y_HI);
  assign w_dy  = 4'(i_y - Y_LO);
  assign w_dx  = 8'(i_x - X_LO);

  // dy*168 as dy*128 + dy*32 + dy*8, plus dx; peak value is 11*168+167 = 2015
  assign w_addr = {w_dy, 7'b0}
                + {2'b0, w_dy, 5'b0}
                + {4'b0, w_dy, 3'b0}
                + {3'b0, w_dx};

  // Opaque, in-box, visible pixel aligned with the ROM byte arriving now
  assign w_draw_next = r_hit2 && r_vis2 && (i_rom_data != KEY_COLOR);

  // Blink FSM: enable drop wins over everything, ticks advance the phase count
  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= 8'd0;
    end else if (!i_enable) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_SHOW;
          r_frame_cnt <= 8'd0;
        end
        ST_SHOW, ST_HIDE: begin
          if (i_frame_tick) begin
            if (r_frame_cnt == LAST_FRAME) begin
              r_state     <= (r_state == ST_SHOW) ? ST_HIDE : ST_SHOW;
              r_frame_cnt <= 8'd0;
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_frame_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Stage 1: ROM address plus hit/visibility captured with the same pixel
  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      o_rom_addr <= 11'd0;
      r_hit1     <= 1'b0;
      r_vis1     <= 1'b0;
    end else begin
      o_rom_addr <= w_hit ? w_addr : 11'd0;
      r_hit1     <= w_hit;
      r_vis1     <= (r_state == ST_SHOW);
    end
  end

  // Stage 2: flags ride alongside the ROM's own output register
  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      r_hit2 <= 1'b0;
      r_vis2 <= 1'b0;
    end else begin
      r_hit2 <= r_hit1;
      r_vis2 <= r_vis1;
    end
  end

  // Stage 3: key out transparent bytes and force 00 when not drawing
  always_ff @(posedge i_clk2 or posedge i_rst) begin
    if (i_rst) begin
      o_draw  <= 1'b0;
      o_pixel <= 8'h00;
    end else begin
      o_draw  <= w_draw_next;
      o_pixel <= w_draw_next ? i_rom_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_press_sprite_draw.sv
// Testbench for press_sprite_draw: behavioural ROM, reference model of the box
// test / blink FSM, and an expected-output queue compared three cycles later.
module tb_press_sprite_draw;

  localparam int BF = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        act;
  logic        tick;
  logic        en;
  logic [10:0] rom_addr;
  logic [7:0]  rom_q;
  logic [7:0]  pixel;
  logic        draw;

  int errors = 0;
  int checks = 0;

  // scoreboard: {draw, pixel} per pixel slot
  logic [8:0] exp_q[$];

  // reference blink state: 0 idle, 1 show, 2 hide
  int m_st;
  int m_cnt;

  press_sprite_draw #(.BLINK_FRAMES(BF)) dut (
    .i_clk2       (clk),
    .i_rst        (rst),
    .i_x          (x),
    .i_y          (y),
    .i_active     (act),
    .i_frame_tick (tick),
    .i_enable     (en),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_q),
    .o_pixel      (pixel),
    .o_draw       (draw)
  );

  // ROM content: address 0 opaque (FF), every 5th address transparent,
  // address 7 holds 3C, everything else a nonzero scramble of the address
  function automatic logic [7:0] rom_val(input logic [10:0] a);
    logic [7:0] v;
    if (a == 11'd0) return 8'hFF;
    if ((a % 11'd5) == 11'd0) return 8'h00;
    if (a == 11'd7) return 8'h3C;
    v = a[7:0] ^ 8'hA5;
    if (v == 8'h00) v = 8'h11;
    return v;
  endfunction

  // one-cycle registered ROM
  always @(posedge clk) rom_q <= rom_val(rom_addr);

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic prefill_after_reset();
    exp_q.delete();
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h000);
    m_st  = 0;
    m_cnt = 0;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive one pixel slot, predict, advance one cycle.
  task automatic step(input int xx, input int yy, input logic a, input logic t, input logic e);
    logic        hit;
    logic [10:0] addr;
    logic [7:0]  d;
    logic        vis;
    logic        dr;
    logic [8:0]  got;
    x    = 10'(xx);
    y    = 10'(yy);
    act  = a;
    tick = t;
    en   = e;
    hit  = a && (xx >= 236) && (xx < 404) && (yy >= 400) && (yy < 412);
    addr = hit ? 11'((yy - 400) * 168 + (xx - 236)) : 11'd0;
    vis  = (m_st == 1);
    d    = rom_val(addr);
    dr   = hit && vis && (d != 8'h00);
    exp_q.push_back({dr, dr ? d : 8'h00});
    if (!e) begin
      m_st = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_cnt = 0;
    end else if (t) begin
      if (m_cnt == BF - 1) begin
        m_st  = (m_st == 1) ? 2 : 1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check("rom_addr", 32'(rom_addr), 32'(addr));
    if (exp_q.size() == 3) begin
      got = exp_q.pop_front();
      check("draw", 32'(draw), 32'(got[8]));
      check("pixel", 32'(pixel), 32'(got[7:0]));
    end
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; x = '0; y = '0; act = 1'b0; tick = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_draw", 32'(draw), 32'd0);
    check("reset_pixel", 32'(pixel), 32'd0);
    check("reset_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    prefill_after_reset();

    // enable the prompt (idle -> show)
    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1);

    // row sweep across the box top row, including both edges
    for (int i = 230; i <= 410; i++) step(i, 400, 1'b1, 1'b0, 1'b1);

    // corners and just-outside coordinates
    step(403, 411, 1'b1, 1'b0, 1'b1);   // last pixel, address 2015
    step(403, 412, 1'b1, 1'b0, 1'b1);   // below box
    step(404, 411, 1'b1, 1'b0, 1'b1);   // right of box
    step(237, 399, 1'b1, 1'b0, 1'b1);   // above box
    step(236, 400, 1'b0, 1'b0, 1'b1);   // inactive at opaque address 0
    step(241, 400, 1'b1, 1'b0, 1'b1);   // key colour byte
    step(243, 400, 1'b1, 1'b0, 1'b1);   // 3C byte
    step(0, 0, 1'b0, 1'b0, 1'b1);

    // blink: each frame tick followed by an opaque in-box probe pixel
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 1'b0, 1'b1, 1'b1);
      step(237, 401, 1'b1, 1'b0, 1'b1);
    end

    // disable together with a tick while hidden, then re-enable
    step(0, 0, 1'b0, 1'b1, 1'b0);
    step(237, 401, 1'b1, 1'b0, 1'b0);
    step(237, 401, 1'b1, 1'b0, 1'b1);
    step(237, 401, 1'b1, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    step(237, 401, 1'b1, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b1);
    step(237, 401, 1'b1, 1'b0, 1'b1);

    // phase toggles mid-line: ticks land between back-to-back in-box pixels
    for (int i = 240; i < 252; i++) step(i, 402, 1'b1, (i == 243 || i == 247), 1'b1);

    // reset with in-box pixels in flight
    step(238, 400, 1'b1, 1'b0, 1'b1);
    step(239, 400, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("midreset_draw", 32'(draw), 32'd0);
    check("midreset_pixel", 32'(pixel), 32'd0);
    check("midreset_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prefill_after_reset();
    for (int i = 236; i < 246; i++) step(i, 400, 1'b1, 1'b0, 1'b1);

    // drain
    repeat (3) step(0, 0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
